sweep_driver: RTL and testbench
===============================

SWEEP_DRIVER -- requirements
Module: sweep_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 3: stimulus width; the sweep covers 2^WIDTH vectors (1..16).
REQ-002 SHALL have parameter RESP_W, default 1: response width (1..16).
REQ-003 SHALL have parameter SETTLE, default 4: settle cycles per vector before sampling (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begins a sweep when sampled high in IDLE.
REQ-007 SHALL have port abort, input, 1, terminates a sweep in progress.
REQ-008 SHALL have port stim, output, WIDTH, stimulus vector driven to the DUT.
REQ-009 SHALL have port resp, input, RESP_W, DUT response.
REQ-010 SHALL have port busy, output, 1, high in SETTLE or SAMPLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at normal sweep completion.
REQ-012 SHALL have port sample_valid, output, 1, one-cycle pulse per sampled vector.
REQ-013 SHALL have port sample_idx, output, WIDTH, stim value of the current sample.
REQ-014 SHALL have port sample_resp, output, RESP_W, resp captured for the current sample.
REQ-015 SHALL have port ones_count, output, WIDTH+1, count of samples with resp[0]==1.
REQ-016 SHALL have port signature, output, 16, response signature (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; busy = (SETTLE or SAMPLE).
REQ-018 IDLE with start=1 SHALL go to SETTLE next cycle: stim=0, settle counter=0, ones_count=0, signature=16'hFFFF.
REQ-019 SETTLE SHALL hold stim constant, increment the counter each cycle, and go to SAMPLE after exactly SETTLE cycles in SETTLE.
REQ-020 The SAMPLE cycle SHALL register, in that cycle, sample_valid=1, sample_idx=stim, sample_resp=resp; it SHALL add resp[0] to ones_count and update signature.
REQ-021 From SAMPLE with stim != 2^WIDTH-1, the FSM SHALL increment stim, clear the counter, and go to SETTLE; otherwise it SHALL go to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE; stim, ones_count, signature SHALL hold until the next start.
REQ-023 Per-vector period SHALL be SETTLE+1 cycles; start-to-done latency SHALL be 2^WIDTH*(SETTLE+1)+1 cycles.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 abort in SETTLE or SAMPLE SHALL return the FSM to IDLE next cycle with no done pulse and no sample_valid in that cycle; stim, ones_count, signature SHALL hold.
REQ-026 abort and start together in IDLE: abort SHALL win; no sweep starts.
REQ-027 stim SHALL not wrap past 2^WIDTH-1 within one sweep; ones_count SHALL reach at most 2^WIDTH without overflow.
REQ-028 sample_valid and done SHALL be low in all other cycles.

Reset
REQ-029 rst SHALL force IDLE, stim=0, busy=0, done=0, sample_valid=0, sample_idx=0, sample_resp=0, ones_count=0, signature=16'hFFFF; it SHALL take priority over start/abort.
REQ-030 rst mid-sweep SHALL abandon the sweep with no done pulse; operation resumes on the next start after rst deasserts.

Configuration
REQ-031 With macro SWEEP_SIGNATURE_EN defined: per sample, signature <= ((sig<<1) ^ (sig[15] ? 16'h1021 : 0)) ^ zero-extended resp.
REQ-032 Without SWEEP_SIGNATURE_EN: the signature register SHALL NOT be built; signature SHALL be tied to 16'h0000, including during reset.

Verification
REQ-033 WIDTH=3, SETTLE=4, resp=&stim: start -> 8 sample_valid pulses at 5-cycle spacing, idx 0..7, done at 41 cycles after start, ones_count=1.
REQ-034 WIDTH=1, RESP_W=1, resp=0, macro defined: full sweep -> signature=16'hCF9F; macro undefined -> 16'h0000.
REQ-035 Abort asserted during the SETTLE of vector 3 -> IDLE next cycle, no done, stim=3 held, ones_count equals the pre-abort count.
REQ-036 start pulsed during busy -> ignored: exactly 2^WIDTH samples and one done pulse.
REQ-037 rst asserted mid-sweep -> all outputs at reset values next cycle; a new start re-runs a full sweep from stim=0.

Source files
------------

// File: rtl/sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : sweep_driver
// Description : Exhaustive stimulus sweep engine. Walks stim through every
//               value 0 .. 2^WIDTH-1, waits SETTLE cycles per vector, then
//               captures the response, counts responses with bit 0 set and
//               optionally folds the responses into a CRC-style signature.
//               Optional feature macro: SWEEP_SIGNATURE_EN (builds the
//               signature register; otherwise signature is tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_driver #(
    parameter int WIDTH  = 3,
    parameter int RESP_W = 1,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [WIDTH-1:0]  stim,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              sample_valid,
    output logic [WIDTH-1:0]  sample_idx,
    output logic [RESP_W-1:0] sample_resp,
    output logic [WIDTH:0]    ones_count,
    output logic [15:0]       signature
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Counter only needs to reach SETTLE-1; keep at least one bit.
    localparam int               c_CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0]   c_STIM_LAST = {WIDTH{1'b1}};
    localparam int               c_OW       = WIDTH + 1;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   stim_q;
    logic               sample_valid_q;
    logic [WIDTH-1:0]   sample_idx_q;
    logic [RESP_W-1:0]  sample_resp_q;
    logic [WIDTH:0]     ones_q;

    // A sweep launches only from IDLE, and abort always beats start.
    logic launch;
    logic take_sample;
    assign launch      = (state_q == c_ST_IDLE)   && start && !abort;
    assign take_sample = (state_q == c_ST_SAMPLE) && !abort;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= c_ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort drops any active sweep straight back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:   if (launch) state_d = c_ST_SETTLE;
            c_ST_SETTLE: begin
                if (abort)                  state_d = c_ST_IDLE;
                else if (cnt_q == c_CNT_LAST) state_d = c_ST_SAMPLE;
            end
            c_ST_SAMPLE: begin
                if (abort)                     state_d = c_ST_IDLE;
                else if (stim_q == c_STIM_LAST) state_d = c_ST_DONE;
                else                           state_d = c_ST_SETTLE;
            end
            default:     state_d = c_ST_IDLE;
        endcase
    end

    // Output decode: status flags follow the state directly.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            c_ST_SETTLE, c_ST_SAMPLE: busy = 1'b1;
            c_ST_DONE:                done = 1'b1;
            default: ;
        endcase
    end

    // Sweep datapath: stimulus, settle counter, captured sample and ones count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            stim_q         <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            sample_resp_q  <= '0;
            ones_q         <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            if (launch) begin
                cnt_q  <= '0;
                stim_q <= '0;
                ones_q <= '0;
            end else if (state_q == c_ST_SETTLE && !abort) begin
                cnt_q <= cnt_q + c_CNT_W'(1);
            end else if (take_sample) begin
                sample_valid_q <= 1'b1;
                sample_idx_q   <= stim_q;
                sample_resp_q  <= resp;
                ones_q         <= ones_q + c_OW'(resp[0]);
                // Stim stops at the last vector so it never wraps mid-sweep.
                if (stim_q != c_STIM_LAST) begin
                    stim_q <= stim_q + WIDTH'(1);
                    cnt_q  <= '0;
                end
            end
        end
    end

    assign stim         = stim_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign sample_resp  = sample_resp_q;
    assign ones_count   = ones_q;

`ifdef SWEEP_SIGNATURE_EN
    logic [15:0] sig_q;
    logic [15:0] sig_d;

    // CCITT-polynomial shift with the response folded into the low bits.
    always_comb begin
        sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(resp);
    end

    // Signature register: seeded on reset and on every new sweep.
    always_ff @(posedge clk) begin
        if (rst)              sig_q <= 16'hFFFF;
        else if (launch)      sig_q <= 16'hFFFF;
        else if (take_sample) sig_q <= sig_d;
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_driver
// Description : Directed self-checking bench for sweep_driver (WIDTH=3,
//               RESP_W=1, SETTLE=4, resp = AND of stim bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_driver;

    localparam int WIDTH  = 3;
    localparam int RESP_W = 1;
    localparam int SETTLE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  stim;
    logic [RESP_W-1:0] resp;
    logic              busy;
    logic              done;
    logic              sample_valid;
    logic [WIDTH-1:0]  sample_idx;
    logic [RESP_W-1:0] sample_resp;
    logic [WIDTH:0]    ones_count;
    logic [15:0]       signature;

    int compared = 0;
    int mismatched = 0;

    sweep_driver #(.WIDTH(WIDTH), .RESP_W(RESP_W), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .stim         (stim),
        .resp         (resp),
        .busy         (busy),
        .done         (done),
        .sample_valid (sample_valid),
        .sample_idx   (sample_idx),
        .sample_resp  (sample_resp),
        .ones_count   (ones_count),
        .signature    (signature)
    );

    always #5 clk = ~clk;

    // Response is 1 only for the all-ones vector.
    assign resp = &stim;

    // Reference signature after the first nvec vectors of a sweep.
    function automatic logic [15:0] sig_model(input int nvec);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int v = 0; v < nvec; v++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ ((v == 7) ? 16'h0001 : 16'h0000);
        end
`ifdef SWEEP_SIGNATURE_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stim"},  32'(stim), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_sv"},    32'(sample_valid), 0);
        check({tag, "_sidx"},  32'(sample_idx), 0);
        check({tag, "_sresp"}, 32'(sample_resp), 0);
        check({tag, "_ones"},  32'(ones_count), 0);
        check({tag, "_sig"},   32'(signature), 32'(sig_model(0)));
    endtask

    // Full sweep from IDLE; optionally pulses start while busy and in DONE.
    task automatic run_sweep(input bit inject);
        int svc;
        int dcount;
        int dn;
        svc = 0; dcount = 0; dn = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("launch_busy", 32'(busy), 1);
        check("launch_stim", 32'(stim), 0);
        check("launch_ones", 32'(ones_count), 0);
        for (int n = 1; n <= 50; n++) begin
            if (sample_valid) begin
                check("sv_time", n, 6 + 5 * svc);
                check("sv_idx", 32'(sample_idx), svc);
                check("sv_resp", 32'(sample_resp), (svc == 7) ? 1 : 0);
                svc++;
            end
            if (done) begin
                dcount++;
                dn = n;
            end
            start = inject && (n == 10 || n == 20 || n == 41);
            step();
        end
        start = 1'b0;
        check("sweep_samples", svc, 8);
        check("sweep_done_cnt", dcount, 1);
        check("sweep_done_time", dn, 41);
        check("sweep_ones", 32'(ones_count), 1);
        check("sweep_sig", 32'(signature), 32'(sig_model(8)));
        check("sweep_stim_hold", 32'(stim), 7);
        check("sweep_idle", 32'(busy), 0);
    endtask

    initial begin
        int cnt_bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("abst_busy", 32'(busy), 0);
        step();
        check("abst_busy2", 32'(busy), 0);
        check("abst_done", 32'(done), 0);

        run_sweep(1'b0);
        run_sweep(1'b1);

        // abort in the SETTLE phase of vector 3
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n < 17; n++) step();
        check("pre_abort_busy", 32'(busy), 1);
        check("pre_abort_stim", 32'(stim), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_stim", 32'(stim), 3);
        check("abort_ones", 32'(ones_count), 0);
        check("abort_sv", 32'(sample_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sig", 32'(signature), 32'(sig_model(3)));
        cnt_bad = 0;
        for (int n = 0; n < 50; n++) begin
            if (done || sample_valid || busy) cnt_bad++;
            step();
        end
        check("abort_quiet", cnt_bad, 0);
        check("abort_stim_hold", 32'(stim), 3);

        // reset in the middle of a sweep
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n < 38; n++) step();
        check("pre_rst_sidx", 32'(sample_idx), 6);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        check_reset_values("midrst");
        rst = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 0);
        run_sweep(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
